// File: rtl/heichips25_pwm_pkg.sv
// ----------------------------------------------------------------------------
// heichips25_pwm_pkg
// Shared constants for the HeiChips25 PWM tile: register map addresses,
// control-pin bit positions and reset values, plus a small decode helper.
// ----------------------------------------------------------------------------
package heichips25_pwm_pkg;

    // Register map (4-bit address space)
    localparam logic [3:0] ADDR_DUTY0    = 4'd0;
    localparam logic [3:0] ADDR_PRESCALE = 4'd8;
    localparam logic [3:0] ADDR_POL      = 4'd9;
    localparam logic [3:0] ADDR_EN       = 4'd10;

    // Control bit positions inside ui_in
    localparam int UI_BIT_WR = 4;
    localparam int UI_BIT_RD = 5;

    // Reset values
    localparam logic [7:0] RST_BYTE = 8'h00;

    // Duty registers occupy the lower half of the address space.
    function automatic logic is_duty_addr(input logic [3:0] addr);
        return (addr[3] == 1'b0);
    endfunction

endpackage

// File: rtl/heichips25_pwm_channel.sv
// ----------------------------------------------------------------------------
// heichips25_pwm_channel
// One PWM channel: shadow duty register (written from the bus), active duty
// register (loaded from shadow on period wrap), compare, polarity/enable and
// a registered output.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   wr_en        load wr_data into the shadow duty register
//   wr_data      new duty value
//   wrap         period wrap pulse; copies shadow -> active
//   cnt          shared period counter
//   en, pol      channel enable and output polarity (unbuffered)
//   shadow       current shadow duty (for readback)
//   pwm          registered PWM output
// ----------------------------------------------------------------------------
module heichips25_pwm_channel
    import heichips25_pwm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             wrap,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    input  logic             pol,
    output logic [CNT_W-1:0] shadow,
    output logic             pwm
);

    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (wr_en) begin
            shadow_d = wr_data;
        end
        // shadow_q (not shadow_d): a write landing on the wrap cycle waits
        // for the following wrap, so a period is never altered mid-way.
        if (wrap) begin
            active_d = shadow_q;
        end
        pwm_d = (en & (cnt < active_q)) ^ pol;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= RST_BYTE[CNT_W-1:0];
            active_q <= RST_BYTE[CNT_W-1:0];
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign shadow = shadow_q;
    assign pwm    = pwm_q;

endmodule

// File: rtl/heichips25_pwm_tile.sv
// ----------------------------------------------------------------------------
// heichips25_pwm_tile
// HeiChips25 tile with NUM_CH PWM channels on uo_out, configured through a
// byte-wide write port. Duty values are double-buffered and switch only at a
// period wrap.
// Ports:
//   ui_in[3:0] register address, ui_in[4] write strobe, ui_in[5] read select
//   uio_in     write data
//   uo_out     registered PWM outputs (bits >= NUM_CH are 0)
//   uio_out    readback data (readback build only, else 0)
//   uio_oe     uio direction, 1 = output (readback build only, else 0)
//   ena        ignored; analog_pin0..3 not driven
//   clk, rst   clock, asynchronous active-high reset
// Build option: define HEICHIPS25_PWM_READBACK_EN to enable register readback.
// ----------------------------------------------------------------------------
module heichips25_pwm_tile
    import heichips25_pwm_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int CNT_W      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst,
    inout  wire        analog_pin0,
    inout  wire        analog_pin1,
    inout  wire        analog_pin2,
    inout  wire        analog_pin3
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [3:0]       NUM_CH_A = 4'(NUM_CH);

    logic [7:0]            ui_s1_q, ui_s1_d, ui_s2_q, ui_s2_d;
    logic [7:0]            uio_s1_q, uio_s1_d, uio_s2_q, uio_s2_d;
    logic                  strobe_prev_q, strobe_prev_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            pol_q, pol_d;
    logic [7:0]            en_q, en_d;

    logic [3:0]            addr;
    logic [7:0]            wdata;
    logic                  wr_re;
    logic                  wr_en;
    logic                  tick;
    logic                  wrap;
    logic [7:0]            pwm_w;
    logic [7:0][CNT_W-1:0] shadow_w;

    assign addr  = ui_s2_q[3:0];
    assign wdata = uio_s2_q;
    assign wr_re = ui_s2_q[UI_BIT_WR] & ~strobe_prev_q;

`ifdef HEICHIPS25_PWM_READBACK_EN
    logic rd_sel;
    assign rd_sel = ui_s2_q[UI_BIT_RD];
    // A read in progress owns the bus; strobes seen meanwhile are discarded.
    assign wr_en  = wr_re & ~rd_sel;
`else
    assign wr_en  = wr_re;
`endif

    always_comb begin
        ui_s1_d       = ui_in;
        ui_s2_d       = ui_s1_q;
        uio_s1_d      = uio_in;
        uio_s2_d      = uio_s1_q;
        strobe_prev_d = ui_s2_q[UI_BIT_WR];

        prescale_d = prescale_q;
        pol_d      = pol_q;
        en_d       = en_q;
        if (wr_en) begin
            case (addr)
                ADDR_PRESCALE: prescale_d = wdata[PRESCALE_W-1:0];
                ADDR_POL:      pol_d      = wdata;
                ADDR_EN:       en_d       = wdata;
                default:       ;
            endcase
        end

        // A prescale written below pcnt lets pcnt run on to its natural
        // roll-over at all-ones before it can match again.
        tick   = (pcnt_q == prescale_q);
        pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
        cnt_d  = tick ? cnt_q + CNT_W'(1) : cnt_q;
        wrap   = tick && (cnt_q == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ui_s1_q       <= RST_BYTE;
            ui_s2_q       <= RST_BYTE;
            uio_s1_q      <= RST_BYTE;
            uio_s2_q      <= RST_BYTE;
            strobe_prev_q <= 1'b0;
            prescale_q    <= RST_BYTE[PRESCALE_W-1:0];
            pcnt_q        <= '0;
            cnt_q         <= '0;
            pol_q         <= RST_BYTE;
            en_q          <= RST_BYTE;
        end else begin
            ui_s1_q       <= ui_s1_d;
            ui_s2_q       <= ui_s2_d;
            uio_s1_q      <= uio_s1_d;
            uio_s2_q      <= uio_s2_d;
            strobe_prev_q <= strobe_prev_d;
            prescale_q    <= prescale_d;
            pcnt_q        <= pcnt_d;
            cnt_q         <= cnt_d;
            pol_q         <= pol_d;
            en_q          <= en_d;
        end
    end

    // Slots >= NUM_CH have no channel, so duty writes there vanish and the
    // corresponding outputs stay 0.
    for (genvar g = 0; g < 8; g++) begin : g_ch
        if (g < NUM_CH) begin : g_on
            logic duty_we;
            assign duty_we = wr_en && is_duty_addr(addr) && (addr == 4'(g));
            heichips25_pwm_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (duty_we),
                .wr_data (wdata[CNT_W-1:0]),
                .wrap    (wrap),
                .cnt     (cnt_q),
                .en      (en_q[g]),
                .pol     (pol_q[g]),
                .shadow  (shadow_w[g]),
                .pwm     (pwm_w[g])
            );
        end else begin : g_off
            assign shadow_w[g] = '0;
            assign pwm_w[g]    = 1'b0;
        end
    end

    assign uo_out = pwm_w;

`ifdef HEICHIPS25_PWM_READBACK_EN
    logic [7:0] rdata;
    logic [7:0] uio_out_q, uio_out_d;
    logic [7:0] uio_oe_q, uio_oe_d;

    always_comb begin
        rdata = '0;
        if (is_duty_addr(addr)) begin
            if (addr < NUM_CH_A) begin
                rdata[CNT_W-1:0] = shadow_w[addr[2:0]];
            end
        end else begin
            case (addr)
                ADDR_PRESCALE: rdata[PRESCALE_W-1:0] = prescale_q;
                ADDR_POL:      rdata = pol_q;
                ADDR_EN:       rdata = en_q;
                default:       rdata = '0;
            endcase
        end
        uio_out_d = rd_sel ? rdata : '0;
        uio_oe_d  = rd_sel ? 8'hFF : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uio_out_q <= '0;
            uio_oe_q  <= '0;
        end else begin
            uio_out_q <= uio_out_d;
            uio_oe_q  <= uio_oe_d;
        end
    end

    assign uio_out = uio_out_q;
    assign uio_oe  = uio_oe_q;
`else
    assign uio_out = '0;
    assign uio_oe  = '0;
`endif

    // Pins and bits with no function in this build.
    logic unused_sink;
    assign unused_sink = &{1'b0, ena, ui_s2_q[7:5], shadow_w,
                           analog_pin0, analog_pin1, analog_pin2, analog_pin3};

endmodule
